// File: rtl/cpu_pc_stack.sv
// rtl/cpu_pc_stack.sv - program-counter stack with call/return nesting
module cpu_pc_stack #(
    parameter int AW    = 14,
    parameter int DEPTH = 8,
    parameter int WRAP  = 1,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          CLK_I,
    input  logic          nRST_I,
    input  logic          STALL_I,
    input  logic          INC_I,
    input  logic          JMP_I,
    input  logic          CALL_I,
    input  logic          RET_I,
    input  logic [AW-1:0] TGT_I,
    input  logic [AW-1:0] LINK_I,
    output logic [AW-1:0] PC_O,
    output logic [IW-1:0] LVL_O,
    output logic          EMPTY_O,
    output logic          FULL_O,
    output logic          OVF_O,
    output logic          UDF_O
);

    logic [AW-1:0] slots [DEPTH];
    logic [IW-1:0] idx;
    logic [IW-1:0] lvl;
    logic [IW-1:0] idx_up;
    logic [IW-1:0] idx_dn;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;

    // Index arithmetic wraps naturally because DEPTH is a power of two.
    assign idx_up = idx + IW'(1);
    assign idx_dn = idx - IW'(1);
    assign empty  = (lvl == '0);
    assign full   = (lvl == IW'(DEPTH - 1));

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            idx <= '0;
            lvl <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            udf <= 1'b0;
            if (!STALL_I) begin
                if (CALL_I) begin
                    if (full && (WRAP == 0)) begin
                        // Saturated: the call degrades to a jump, the link is lost.
                        slots[idx] <= TGT_I;
                        ovf        <= 1'b1;
                    end else begin
                        slots[idx]    <= LINK_I;
                        slots[idx_up] <= TGT_I;
                        idx           <= idx_up;
                        if (!full) begin
                            lvl <= lvl + IW'(1);
                        end
                        ovf <= full;
                    end
                end else if (RET_I) begin
                    if (empty && (WRAP == 0)) begin
                        udf <= 1'b1;
                    end else begin
                        idx <= idx_dn;
                        if (!empty) begin
                            lvl <= lvl - IW'(1);
                        end
                        udf <= empty;
                    end
                end else if (JMP_I) begin
                    slots[idx] <= TGT_I;
                end else if (INC_I) begin
                    slots[idx] <= slots[idx] + AW'(1);
                end
            end
        end
    end

    assign PC_O    = slots[idx];
    assign LVL_O   = lvl;
    assign EMPTY_O = empty;
    assign FULL_O  = full;
    assign OVF_O   = ovf;
    assign UDF_O   = udf;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// tb/tb_cpu_pc_stack.sv - directed vector bench for cpu_pc_stack
module tb_cpu_pc_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, inc, jmp, call, ret;
    logic [13:0] tgt, link;

    logic [13:0] pc_w, pc_s;
    logic [2:0]  lvl_w, lvl_s;
    logic        empty_w, empty_s, full_w, full_s;
    logic        ovf_w, ovf_s, udf_w, udf_s;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cpu_pc_stack #(.AW(14), .DEPTH(8), .WRAP(1)) u_wrap (
        .CLK_I(clk), .nRST_I(rst_n), .STALL_I(stall), .INC_I(inc), .JMP_I(jmp),
        .CALL_I(call), .RET_I(ret), .TGT_I(tgt), .LINK_I(link),
        .PC_O(pc_w), .LVL_O(lvl_w), .EMPTY_O(empty_w), .FULL_O(full_w),
        .OVF_O(ovf_w), .UDF_O(udf_w)
    );

    cpu_pc_stack #(.AW(14), .DEPTH(8), .WRAP(0)) u_sat (
        .CLK_I(clk), .nRST_I(rst_n), .STALL_I(stall), .INC_I(inc), .JMP_I(jmp),
        .CALL_I(call), .RET_I(ret), .TGT_I(tgt), .LINK_I(link),
        .PC_O(pc_s), .LVL_O(lvl_s), .EMPTY_O(empty_s), .FULL_O(full_s),
        .OVF_O(ovf_s), .UDF_O(udf_s)
    );

    typedef struct {
        string       name;
        logic        stall, inc, jmp, call, ret;
        logic [13:0] tgt, link;
        logic [13:0] pc;
        logic [2:0]  lvl;
        logic        empty, full, ovf, udf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic i, input logic j, input logic c,
                         input logic r, input logic [13:0] t, input logic [13:0] l);
        @(negedge clk);
        stall = s; inc = i; jmp = j; call = c; ret = r; tgt = t; link = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 14'h0, 14'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall = 0; inc = 0; jmp = 0; call = 0; ret = 0; tgt = '0; link = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; inc = 0; jmp = 0; call = 0; ret = 0; tgt = '0; link = '0;

        //            name         stl inc jmp cal ret tgt      link     pc       lvl emp ful ovf udf
        vecs[0]  = '{"inc1",        0,  1,  0,  0,  0, 14'h0,   14'h0,   14'h0001, 0,  1,  0,  0,  0};
        vecs[1]  = '{"inc2",        0,  1,  0,  0,  0, 14'h0,   14'h0,   14'h0002, 0,  1,  0,  0,  0};
        vecs[2]  = '{"inc3",        0,  1,  0,  0,  0, 14'h0,   14'h0,   14'h0003, 0,  1,  0,  0,  0};
        vecs[3]  = '{"jmp5",        0,  0,  1,  0,  0, 14'h5,   14'h0,   14'h0005, 0,  1,  0,  0,  0};
        vecs[4]  = '{"call1200",    0,  0,  0,  1,  0, 14'h1200,14'h6,   14'h1200, 1,  0,  0,  0,  0};
        vecs[5]  = '{"ret6",        0,  0,  0,  0,  1, 14'h0,   14'h0,   14'h0006, 0,  1,  0,  0,  0};
        vecs[6]  = '{"call_prio",   0,  1,  0,  1,  1, 14'h200, 14'h7,   14'h0200, 1,  0,  0,  0,  0};
        vecs[7]  = '{"stall_call",  1,  0,  0,  1,  0, 14'h300, 14'h9,   14'h0200, 1,  0,  0,  0,  0};
        vecs[8]  = '{"ret_prio",    0,  1,  1,  0,  1, 14'h55,  14'h0,   14'h0007, 0,  1,  0,  0,  0};
        vecs[9]  = '{"jmp3fff",     0,  1,  1,  0,  0, 14'h3FFF,14'h0,   14'h3FFF, 0,  1,  0,  0,  0};
        vecs[10] = '{"inc_wrap",    0,  1,  0,  0,  0, 14'h0,   14'h0,   14'h0000, 0,  1,  0,  0,  0};
        vecs[11] = '{"hold",        0,  0,  0,  0,  0, 14'h123, 14'h0,   14'h0000, 0,  1,  0,  0,  0};
        vecs[12] = '{"ret_empty",   0,  0,  0,  0,  1, 14'h0,   14'h0,   14'h0000, 0,  1,  0,  0,  1};
        vecs[13] = '{"udf_clear",   0,  0,  0,  0,  0, 14'h0,   14'h0,   14'h0000, 0,  1,  0,  0,  0};

        #2;
        chk("rst_async_pc", 32'(pc_w), 0);
        chk("rst_async_empty", 32'(empty_w), 1);
        chk("rst_async_full", 32'(full_w), 0);
        do_reset();
        #1;
        chk("rst_pc", 32'(pc_w), 0);
        chk("rst_lvl", 32'(lvl_w), 0);
        chk("rst_ovf_udf", {30'd0, ovf_w, udf_w}, 0);

        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].stall, vecs[v].inc, vecs[v].jmp, vecs[v].call, vecs[v].ret,
                  vecs[v].tgt, vecs[v].link);
            chk({vecs[v].name, "_pc"}, 32'(pc_w), 32'(vecs[v].pc));
            chk({vecs[v].name, "_lvl"}, 32'(lvl_w), 32'(vecs[v].lvl));
            chk({vecs[v].name, "_flags"}, {28'd0, empty_w, full_w, ovf_w, udf_w},
                {28'd0, vecs[v].empty, vecs[v].full, vecs[v].ovf, vecs[v].udf});
        end

        // Eight nested calls: wrap overwrites the oldest, saturate degrades to jump.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 1, 0, 14'(16'h100 + k), 14'(k));
            chk($sformatf("call%0d_pc_w", k), 32'(pc_w), 32'h100 + k);
            chk($sformatf("call%0d_pc_s", k), 32'(pc_s), 32'h100 + k);
            chk($sformatf("call%0d_lvl_w", k), 32'(lvl_w), (k < 8) ? k : 7);
            chk($sformatf("call%0d_lvl_s", k), 32'(lvl_s), (k < 8) ? k : 7);
            chk($sformatf("call%0d_full_w", k), 32'(full_w), (k >= 7) ? 1 : 0);
            chk($sformatf("call%0d_ovf_w", k), 32'(ovf_w), (k == 8) ? 1 : 0);
            chk($sformatf("call%0d_ovf_s", k), 32'(ovf_s), (k == 8) ? 1 : 0);
        end
        for (int j = 1; j <= 7; j++) begin
            drive(0, 0, 0, 0, 1, 14'h0, 14'h0);
            chk($sformatf("ret%0d_pc_w", j), 32'(pc_w), 9 - j);
            chk($sformatf("ret%0d_pc_s", j), 32'(pc_s), 8 - j);
            chk($sformatf("ret%0d_lvl_w", j), 32'(lvl_w), 7 - j);
            chk($sformatf("ret%0d_ovf_w", j), 32'(ovf_w), 0);
        end
        drive(0, 0, 0, 0, 1, 14'h0, 14'h0);
        chk("ret_empty_pc_w", 32'(pc_w), 32'h108);
        chk("ret_empty_pc_s", 32'(pc_s), 1);
        chk("ret_empty_lvl_w", 32'(lvl_w), 0);
        chk("ret_empty_udf_w", 32'(udf_w), 1);
        chk("ret_empty_udf_s", 32'(udf_s), 1);
        idle();
        chk("udf_pulse_w", 32'(udf_w), 0);
        chk("udf_pulse_s", 32'(udf_s), 0);
        chk("hold_pc_s", 32'(pc_s), 1);

        // Stall on the faulting call must also suppress the fault pulse.
        for (int k = 1; k <= 7; k++) drive(0, 0, 0, 1, 0, 14'(16'h200 + k), 14'(k));
        drive(1, 0, 0, 1, 0, 14'h2FF, 14'h99);
        chk("stall_full_ovf_w", 32'(ovf_w), 0);
        chk("stall_full_ovf_s", 32'(ovf_s), 0);
        chk("stall_full_pc_s", 32'(pc_s), 32'h207);

        // Asynchronous reset between edges at depth 3.
        do_reset();
        for (int k = 1; k <= 3; k++) drive(0, 0, 0, 1, 0, 14'(16'h300 + k), 14'(k));
        chk("pre_rst_lvl", 32'(lvl_w), 3);
        @(negedge clk);
        call = 1; tgt = 14'h3AA; link = 14'h3BB;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc_w), 0);
        chk("mid_rst_lvl", 32'(lvl_w), 0);
        chk("mid_rst_empty", 32'(empty_w), 1);
        @(posedge clk);
        #1;
        chk("held_rst_pc", 32'(pc_w), 0);
        @(negedge clk);
        call = 0; inc = 1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_cmd_pc", 32'(pc_w), 1);
        chk("first_cmd_lvl", 32'(lvl_w), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
